debounce_scheduler: RTL and testbench
=====================================

// Module: debounce_scheduler
// PURPOSE
//  Debounces N_BTN raw push-buttons with one shared ms prescaler and per-channel hold counters.
//  Turns each confirmed press into an event; one event per cycle is queued into a FIFO.
//  Drains to the game logic over a valid/ready port. Sits between board buttons and BinGo game control.
// PARAMETERS
//  N_BTN      4       number of button channels (1..16)
//  TICK_DIV   100000  clk cycles per ms tick (>=2)
//  HOLD_MS    16      ms ticks of stable level needed for press / release lockout (1..255)
//  FIFO_DEPTH 4       event FIFO entries (power of 2, >=2)
// PORTS
//  clk           in   1                  system clock
//  rst           in   1                  reset; one clock; reset is synchronous and active-high
//  btn_raw       in   N_BTN              asynchronous raw buttons, active-high
//  btn_level     out  N_BTN              debounced level, 1 while channel in PRESSED
//  evt_valid     out  1                  FIFO non-empty
//  evt_ready     in   1                  consumer accepts head when evt_valid&evt_ready
//  evt_id        out  max(1,clog2(N_BTN)) channel index of FIFO head
//  evt_kind      out  1                  0=press, 1=release (see CONFIGURATION)
//  evt_overflow  out  1                  sticky: an event was lost
//  clr_overflow  in   1                  clears evt_overflow
// BEHAVIOUR
//  Reset: all outputs 0; prescaler=0; FSMs IDLE; counters 0; pending bits 0; FIFO empty.
//  Sync: 2-flop synchroniser per btn_raw bit; FSMs use stage-2 value s[i].
//  Prescaler: free-running 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1.
//  Per-channel FSM, one-hot {IDLE,WAIT_PRESS,PRESSED,WAIT_RELEASE}, 8-bit ms counter cnt[i]:
//   IDLE:         s=1 -> WAIT_PRESS, cnt=0.
//   WAIT_PRESS:   s=0 -> IDLE (glitch, no event); tick&s & cnt==HOLD_MS-1 -> PRESSED;
//                 else tick -> cnt+1.
//   PRESSED:      s=0 -> WAIT_RELEASE, cnt=0.
//   WAIT_RELEASE: input ignored (bounce lockout); tick & cnt==HOLD_MS-1 -> IDLE; else tick -> cnt+1.
//  Effective hold is HOLD_MS-1..HOLD_MS tick periods (first tick partial); this is accepted.
//  Entry into PRESSED sets pend_p[i]; btn_level[i] is registered, =1 from that entry cycle+1.
//  Scheduler: each cycle, if FIFO not full (or popping same cycle), push lowest-index
//   pending event and clear its bit. Release events (if enabled) rank after all press events.
//  Set and clear of the same pend bit in one cycle: the set wins if it is a new event.
//   If the bit was already set (pending unserved), the new event is dropped and evt_overflow=1.
//  FIFO full: pend bits hold, nothing dropped until a second event on the same channel.
//  Push and pop in the same cycle when full are both legal; count unchanged.
//  Latency: final qualifying tick -> PRESSED +1 -> pend +1 -> FIFO push +1; evt_valid visible
//   3 cycles after the tick when the FIFO is empty and there is no contention.
//  evt_id/evt_kind are stable while evt_valid & !evt_ready.
//  clr_overflow clears the flag; if an overflow coincides in the same cycle, the flag stays 1.
//  rst mid-operation: FIFO, pend bits and FSMs flush immediately; a button still held after rst
//   is re-qualified from IDLE (a new press event after HOLD_MS).
// CONFIGURATION
//  DEBOUNCE_RELEASE_EVT_EN defined: WAIT_RELEASE entry sets pend_r[i]; release events are queued
//   with evt_kind=1 and follow the same overflow rules (per-kind pend bit).
//  Not defined: no pend_r logic; evt_kind tied to 0; only press events are queued.
// TESTING (TICK_DIV=4, HOLD_MS=3, N_BTN=4, FIFO_DEPTH=4)
//  btn_raw[2] high 40 cyc, evt_ready=1 -> one event id=2 kind=0; btn_level[2]=1 until release.
//  btn_raw[1] pulses high 5 cyc then low -> no event, btn_level[1] stays 0.
//  bounce toggling every 2 cyc for 10 cyc after release -> no extra event (lockout holds).
//  btn[3] and btn[0] rise same cycle -> events id=0 then id=3 on consecutive cycles.
//  evt_ready=0, 6 distinct presses -> 4 in FIFO; 2nd press on a pended channel sets
//   evt_overflow; clr_overflow clears it.
//  DEBOUNCE_RELEASE_EVT_EN defined, press+release ch1 -> id=1 kind=0 then id=1 kind=1;
//   rst mid-WAIT_PRESS -> no event.

Source files
------------

// File: rtl/debounce_scheduler_if.sv
// debounce_scheduler_if: event stream port carrying valid/ready, event id/kind and the overflow flag/clear
// master: drives evt_valid, evt_id, evt_kind, evt_overflow; receives evt_ready, clr_overflow
// slave:  the consumer side of the same signals
interface debounce_scheduler_if #(parameter int ID_W = 2);
  logic evt_valid;
  logic evt_ready;
  logic [ID_W-1:0] evt_id;
  logic evt_kind;
  logic evt_overflow;
  logic clr_overflow;
  modport master(output evt_valid, evt_id, evt_kind, evt_overflow, input evt_ready, clr_overflow);
  modport slave(input evt_valid, evt_id, evt_kind, evt_overflow, output evt_ready, clr_overflow);
endinterface

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: debounces N_BTN buttons and queues press (and optionally release) events into a FIFO
// clk, rst      : clock, synchronous active-high reset
// btn_raw       : asynchronous raw buttons, active-high
// btn_level     : debounced level per channel
// evt (master)  : evt_valid/evt_ready/evt_id/evt_kind event stream, sticky evt_overflow, clr_overflow
// Macro DEBOUNCE_RELEASE_EVT_EN adds release events (evt_kind=1); otherwise evt_kind is tied to 0.
module debounce_scheduler #(
  parameter int N_BTN = 4,
  parameter int TICK_DIV = 100000,
  parameter int HOLD_MS = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  debounce_scheduler_if.master evt
);
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MS - 1);
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    WAIT_PRESS = 4'b0010,
    PRESSED = 4'b0100,
    WAIT_RELEASE = 4'b1000
  } state_t;
  logic [PW-1:0] pcnt;
  logic tick;
  logic [N_BTN-1:0] s1, s;
  state_t st [N_BTN];
  logic [7:0] cnt [N_BTN];
  logic [N_BTN-1:0] ent_p, pend_p, clr_p, onehot;
  logic [ID_W-1:0] sel_id;
  logic sel_any, push, pop, full, ovf_evt;
  logic [AW:0] count;
  logic [AW-1:0] wp, rp;
  logic [ID_W-1:0] mem_id [FIFO_DEPTH];
`ifdef DEBOUNCE_RELEASE_EVT_EN
  logic [N_BTN-1:0] ent_r, pend_r, clr_r;
  logic sel_kind;
  logic mem_kind [FIFO_DEPTH];
`endif
  assign tick = pcnt == PW'(TICK_DIV - 1);
  always_ff @(posedge clk)
    pcnt <= (rst | tick) ? '0 : pcnt + PW'(1);
  always_ff @(posedge clk)
    {s, s1} <= rst ? '0 : {s1, btn_raw};
  // ent_p/ent_r pulse for one cycle on the first cycle spent in PRESSED/WAIT_RELEASE
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      ent_p[i] <= 1'b0;
`ifdef DEBOUNCE_RELEASE_EVT_EN
      ent_r[i] <= 1'b0;
`endif
      btn_level[i] <= st[i] == PRESSED;
      if (rst) begin
        st[i] <= IDLE;
        cnt[i] <= '0;
        btn_level[i] <= 1'b0;
      end else begin
        case (st[i])
          IDLE: if (s[i]) begin
            st[i] <= WAIT_PRESS;
            cnt[i] <= '0;
          end
          WAIT_PRESS:
            if (!s[i]) st[i] <= IDLE;
            else if (tick && cnt[i] == HOLD_LAST) begin
              st[i] <= PRESSED;
              ent_p[i] <= 1'b1;
            end else if (tick) cnt[i] <= cnt[i] + 8'd1;
          PRESSED: if (!s[i]) begin
            st[i] <= WAIT_RELEASE;
            cnt[i] <= '0;
`ifdef DEBOUNCE_RELEASE_EVT_EN
            ent_r[i] <= 1'b1;
`endif
          end
          WAIT_RELEASE:
            if (tick && cnt[i] == HOLD_LAST) st[i] <= IDLE;
            else if (tick) cnt[i] <= cnt[i] + 8'd1;
          default: st[i] <= IDLE;
        endcase
      end
    end
  end
  // lowest pending index wins; the press scan runs last so presses outrank releases
  always_comb begin
    sel_id = '0;
`ifdef DEBOUNCE_RELEASE_EVT_EN
    for (int i = N_BTN - 1; i >= 0; i--)
      if (pend_r[i]) sel_id = ID_W'(i);
`endif
    for (int i = N_BTN - 1; i >= 0; i--)
      if (pend_p[i]) sel_id = ID_W'(i);
  end
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign pop = evt.evt_valid & evt.evt_ready;
  assign push = sel_any & (~full | pop);
  assign onehot = push ? N_BTN'(1) << sel_id : '0;
`ifdef DEBOUNCE_RELEASE_EVT_EN
  assign sel_kind = ~|pend_p;
  assign sel_any = (|pend_p) | (|pend_r);
  assign clr_p = sel_kind ? '0 : onehot;
  assign clr_r = sel_kind ? onehot : '0;
  assign ovf_evt = (|(ent_p & pend_p & ~clr_p)) | (|(ent_r & pend_r & ~clr_r));
  assign evt.evt_kind = evt.evt_valid ? mem_kind[rp] : 1'b0;
`else
  assign sel_any = |pend_p;
  assign clr_p = onehot;
  assign ovf_evt = |(ent_p & pend_p & ~clr_p);
  assign evt.evt_kind = 1'b0;
`endif
  assign evt.evt_valid = count != '0;
  assign evt.evt_id = evt.evt_valid ? mem_id[rp] : '0;
  // a new entry on a bit being served this cycle survives; one on an unserved bit is lost
  always_ff @(posedge clk)
    if (rst) begin
      pend_p <= '0;
`ifdef DEBOUNCE_RELEASE_EVT_EN
      pend_r <= '0;
`endif
      count <= '0;
      wp <= '0;
      rp <= '0;
      evt.evt_overflow <= 1'b0;
    end else begin
      pend_p <= (pend_p & ~clr_p) | ent_p;
`ifdef DEBOUNCE_RELEASE_EVT_EN
      pend_r <= (pend_r & ~clr_r) | ent_r;
`endif
      if (push) begin
        mem_id[wp] <= sel_id;
`ifdef DEBOUNCE_RELEASE_EVT_EN
        mem_kind[wp] <= sel_kind;
`endif
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      evt.evt_overflow <= ovf_evt | (evt.evt_overflow & ~evt.clr_overflow);
    end
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed and random stimulus checked every cycle against a timeline model
module tb_debounce_scheduler;
  localparam int N = 4, TD = 4, H = 3, D = 4;
`ifdef DEBOUNCE_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] btn_raw = '0, btn_level;
  debounce_scheduler_if #(.ID_W(2)) evt ();
  debounce_scheduler #(.N_BTN(N), .TICK_DIV(TD), .HOLD_MS(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level), .evt(evt)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int t;
  int mode [N];
  int since [N];
  bit [N-1:0] d1, d2, arr_p, arr_r, pend_p, pend_r, lvl, lvl_seen;
  bit ovf, live = 1'b0;
  bit [2:0] q[$];
  bit [2:0] log_q[$];
  longint log_t[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask
  // tick periods k with k%TD==TD-1 inside the cycle window [a,b]
  function automatic int ticks(input int a, input int b);
    return (b + 1) / TD - a / TD;
  endfunction
  task automatic model_reset();
    t = 0;
    d1 = '0; d2 = '0; arr_p = '0; arr_r = '0; pend_p = '0; pend_r = '0; lvl = '0; ovf = 1'b0;
    q.delete();
    for (int i = 0; i < N; i++) begin
      mode[i] = 0;
      since[i] = 0;
    end
  endtask
  // modes: 0 idle, 1 qualifying since 'since', 2 held, 3 lockout since 'since'
  task automatic model_step();
    bit pop, sk, tk, lost;
    int sel;
    bit [N-1:0] s;
    s = d2;
    pop = q.size() > 0 && evt.evt_ready;
    sel = -1;
    sk = 1'b0;
    if (q.size() < D || pop) begin
      for (int i = 0; i < N && sel < 0; i++) if (pend_p[i]) sel = i;
      for (int i = 0; i < N && sel < 0; i++) if (pend_r[i]) begin sel = i; sk = 1'b1; end
    end
    if (sel >= 0) begin
      if (sk) pend_r[sel] = 1'b0;
      else pend_p[sel] = 1'b0;
    end
    lost = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (arr_p[i]) begin lost |= pend_p[i]; pend_p[i] = 1'b1; end
      if (arr_r[i]) begin lost |= pend_r[i]; pend_r[i] = 1'b1; end
    end
    if (pop) void'(q.pop_front());
    if (sel >= 0) q.push_back({sk, 2'(sel)});
    ovf = lost ? 1'b1 : (evt.clr_overflow ? 1'b0 : ovf);
    for (int i = 0; i < N; i++) lvl[i] = mode[i] == 2;
    arr_p = '0;
    arr_r = '0;
    tk = (t % TD) == TD - 1;
    for (int i = 0; i < N; i++)
      case (mode[i])
        0: if (s[i]) begin mode[i] = 1; since[i] = t + 1; end
        1: if (!s[i]) mode[i] = 0;
           else if (tk && ticks(since[i], t) == H) begin mode[i] = 2; arr_p[i] = 1'b1; end
        2: if (!s[i]) begin mode[i] = 3; since[i] = t + 1; arr_r[i] = REL; end
        default: if (tk && ticks(since[i], t) == H) mode[i] = 0;
      endcase
    d2 = d1;
    d1 = btn_raw;
    t++;
  endtask
  initial forever begin
    @(posedge clk);
    if (rst) begin
      model_reset();
      live = 1'b1;
    end else if (live) model_step();
  end
  initial forever begin
    @(negedge clk);
    if (live && !rst) begin
      chk("btn_level", btn_level, lvl);
      chk("evt_valid", evt.evt_valid, q.size() > 0);
      if (q.size() > 0) chk("evt_head", {evt.evt_kind, evt.evt_id}, q[0]);
      chk("evt_overflow", evt.evt_overflow, ovf);
      lvl_seen |= btn_level;
      if (evt.evt_valid && evt.evt_ready) begin
        log_q.push_back({evt.evt_kind, evt.evt_id});
        log_t.push_back($time);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic new_phase();
    log_q.delete();
    log_t.delete();
    lvl_seen = '0;
  endtask
  initial begin
    int seq [6] = '{0, 1, 2, 3, 0, 0};
    evt.evt_ready = 1'b1;
    evt.clr_overflow = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_valid", evt.evt_valid, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_ovf", evt.evt_overflow, 0);
    new_phase();
    btn_raw[2] = 1'b1;
    step(35);
    chk("hold_level2", btn_level, 4'b0100);
    step(5);
    btn_raw[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(2);
      btn_raw[2] = ~btn_raw[2];
    end
    step(30);
    chk("press2_count", log_q.size(), 1 + REL);
    if (log_q.size() > 0) chk("press2_head", log_q[0], 3'b010);
    if (REL && log_q.size() > 1) chk("release2_head", log_q[1], 3'b110);
    new_phase();
    btn_raw[1] = 1'b1;
    step(5);
    btn_raw[1] = 1'b0;
    step(25);
    chk("glitch_count", log_q.size(), 0);
    chk("glitch_level1", lvl_seen[1], 0);
    new_phase();
    btn_raw = 4'b1001;
    step(30);
    btn_raw = '0;
    step(35);
    chk("pair_count", log_q.size(), 2 + 2 * REL);
    if (log_q.size() > 1) begin
      chk("pair_first", log_q[0], 3'b000);
      chk("pair_second", log_q[1], 3'b011);
      chk("pair_gap", 32'(log_t[1] - log_t[0]), 10);
    end
    new_phase();
    evt.evt_ready = 1'b0;
    foreach (seq[k]) begin
      btn_raw[seq[k]] = 1'b1;
      step(24);
      btn_raw[seq[k]] = 1'b0;
      step(24);
    end
    chk("full_valid", evt.evt_valid, 1);
    chk("full_ovf", evt.evt_overflow, 1);
    evt.clr_overflow = 1'b1;
    step(1);
    evt.clr_overflow = 1'b0;
    chk("clr_ovf", evt.evt_overflow, 0);
    evt.evt_ready = 1'b1;
    step(20);
    chk("drain_count", log_q.size(), REL ? 10 : 5);
    if (log_q.size() > 0) chk("drain_first", log_q[0], 3'b000);
    new_phase();
    btn_raw[1] = 1'b1;
    step(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(6);
    btn_raw[1] = 1'b0;
    step(30);
    chk("rst_mid_count", log_q.size(), 0);
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, (k < 2000) ? 9 : 24) == 0) btn_raw[i] = ~btn_raw[i];
      evt.evt_ready = ((k / 250) % 3 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      evt.clr_overflow = $urandom_range(0, 40) == 0;
      rst = $urandom_range(0, 799) == 0;
      step(1);
    end
    rst = 1'b0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
